issue_scoreboard: RTL and testbench

//  Register-hazard scoreboard between the instruction decoder and the execute/writeback pipe.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/sb_counter.sv | 41 ++++
 rtl/issue_scoreboard.sv | 83 ++++++++
 tb/tb_issue_scoreboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide definitions: architectural register file geometry.
package cpu_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;

    typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/sb_counter.sv
// One in-flight write counter for a single architectural register.
// Simultaneous inc and dec cancel. The count never wraps in either direction.
module sb_counter
    import cpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic nz,
    output logic is_one,
    output logic is_max,
    output logic udf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Count register: clear wins, then a net increment or decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
        end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
    end

    assign nz     = (cnt != '0);
    assign is_one = (cnt == CNT_ONE);
    assign is_max = (cnt == CNT_MAX);
    // A lone decrement at zero means a writeback with no matching issue.
    assign udf    = dec && !inc && !clr && (cnt == '0);
endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard: holds decoder issue while a source register has an
// outstanding write or the destination's in-flight count is saturated.
module issue_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int REG_W    = cpu_pkg::REG_W,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1,
    parameter int STALL_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [REG_W-1:0]   rs_sel,
    input  logic               rs_used,
    input  logic [REG_W-1:0]   rt_sel,
    input  logic               rt_used,
    input  logic [REG_W-1:0]   dst_sel,
    input  logic               dst_write,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_sel,
    input  logic               flush,
    output logic               busy,
    output logic               underflow,
    output logic [STALL_W-1:0] stall_cnt
);
    logic [NUM_REGS-1:0] nz_v;
    logic [NUM_REGS-1:0] one_v;
    logic [NUM_REGS-1:0] max_v;
    logic [NUM_REGS-1:0] udf_v;
    logic                issue_fire;
    logic                pend_rs;
    logic                pend_rt;
    logic                dst_full;

    // Register 0 is hardwired and never carries a hazard.
    assign nz_v[0]  = 1'b0;
    assign one_v[0] = 1'b0;
    assign max_v[0] = 1'b0;
    assign udf_v[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .inc    (issue_fire && dst_write && (dst_sel == REG_W'(g))),
            .dec    (wb_valid && (wb_sel == REG_W'(g))),
            .clr    (flush),
            .nz     (nz_v[g]),
            .is_one (one_v[g]),
            .is_max (max_v[g]),
            .udf    (udf_v[g])
        );
    end

    // A source is pending unless its last outstanding write lands this very cycle.
    always_comb begin
        pend_rs = nz_v[rs_sel];
        pend_rt = nz_v[rt_sel];
        if ((BYPASS != 0) && wb_valid && (wb_sel == rs_sel) && one_v[rs_sel]) pend_rs = 1'b0;
        if ((BYPASS != 0) && wb_valid && (wb_sel == rt_sel) && one_v[rt_sel]) pend_rt = 1'b0;
        dst_full    = dst_write && (dst_sel != '0) && max_v[dst_sel];
        issue_ready = !flush && !(rs_used && pend_rs) && !(rt_used && pend_rt) && !dst_full;
    end

    assign issue_fire = issue_valid && issue_ready;
    assign busy       = |nz_v;

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) underflow <= 1'b0;
        else if (|udf_v) underflow <= 1'b1;
    end

    // Saturating count of cycles where the decoder waited on us.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else if (issue_valid && !issue_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_W'(1);
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: two scoreboards (bypass on / off) driven in parallel and
// compared every cycle against a behavioural model through an expectation queue.
module tb_issue_scoreboard;
    import cpu_pkg::*;

    localparam int MAXC = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, rs_used, rt_used, dst_write, wb_valid, flush;
    logic [4:0]  rs_sel, rt_sel, dst_sel, wb_sel;
    logic        ready_o [2];
    logic        busy_o  [2];
    logic        udf_o   [2];
    logic [15:0] stall_o [2];

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        udf;
        logic [15:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   mcnt   [2][32];
    int   mstall [2];
    bit   mudf   [2];

    always #5 clock = ~clock;

    issue_scoreboard #(.BYPASS(1)) u_byp (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(ready_o[0]),
        .rs_sel(rs_sel), .rs_used(rs_used), .rt_sel(rt_sel), .rt_used(rt_used),
        .dst_sel(dst_sel), .dst_write(dst_write), .wb_valid(wb_valid), .wb_sel(wb_sel),
        .flush(flush), .busy(busy_o[0]), .underflow(udf_o[0]), .stall_cnt(stall_o[0])
    );

    issue_scoreboard #(.BYPASS(0)) u_nobyp (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(ready_o[1]),
        .rs_sel(rs_sel), .rs_used(rs_used), .rt_sel(rt_sel), .rt_used(rt_used),
        .dst_sel(dst_sel), .dst_write(dst_write), .wb_valid(wb_valid), .wb_sel(wb_sel),
        .flush(flush), .busy(busy_o[1]), .underflow(udf_o[1]), .stall_cnt(stall_o[1])
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit m_pend(int m, int r);
        if (r == 0 || mcnt[m][r] == 0) return 1'b0;
        if (m == 0 && wb_valid && int'(wb_sel) == r && mcnt[m][r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready(int m);
        if (flush) return 1'b0;
        if (rs_used && m_pend(m, int'(rs_sel))) return 1'b0;
        if (rt_used && m_pend(m, int'(rt_sel))) return 1'b0;
        if (dst_write && dst_sel != 0 && mcnt[m][int'(dst_sel)] == MAXC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_busy(int m);
        for (int r = 0; r < 32; r++) if (mcnt[m][r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 32; r++) mcnt[m][r] = 0;
            mstall[m] = 0;
            mudf[m]   = 1'b0;
        end
    endtask

    task automatic step(input bit iv, input bit rsu, input int rs, input bit rtu, input int rt,
                        input bit dw, input int d, input bit wv, input int w, input bit fl,
                        input string tag);
        bit   rdy [2];
        exp_t e;
        @(negedge clock);
        issue_valid = iv; rs_used = rsu; rs_sel = 5'(rs); rt_used = rtu; rt_sel = 5'(rt);
        dst_write = dw; dst_sel = 5'(d); wb_valid = wv; wb_sel = 5'(w); flush = fl;
        #1;
        for (int m = 0; m < 2; m++) begin
            rdy[m]  = m_ready(m);
            e.ready = rdy[m];
            e.busy  = m_busy(m);
            e.udf   = mudf[m];
            e.stall = 16'(mstall[m]);
            exp_q.push_back(e);
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            string sfx;
            sfx = (m == 0) ? "/byp" : "/nobyp";
            e = exp_q.pop_front();
            check_val({tag, sfx, ".ready"}, 32'(ready_o[m]), 32'(e.ready));
            check_val({tag, sfx, ".busy"},  32'(busy_o[m]),  32'(e.busy));
            check_val({tag, sfx, ".udf"},   32'(udf_o[m]),   32'(e.udf));
            check_val({tag, sfx, ".stall"}, 32'(stall_o[m]), 32'(e.stall));
        end
        @(posedge clock);
        for (int m = 0; m < 2; m++) begin
            if (iv && !rdy[m] && mstall[m] != 16'hFFFF) mstall[m]++;
            if (fl) begin
                for (int r = 0; r < 32; r++) mcnt[m][r] = 0;
            end else begin
                bit inc, dec;
                inc = iv && rdy[m] && dw && d != 0;
                dec = wv && w != 0;
                if (!(inc && dec && d == w)) begin
                    if (inc) mcnt[m][d]++;
                    if (dec) begin
                        if (mcnt[m][w] == 0) mudf[m] = 1'b1;
                        else mcnt[m][w]--;
                    end
                end
            end
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 0; rs_used = 0; rt_used = 0; dst_write = 0; wb_valid = 0; flush = 0;
        rs_sel = 0; rt_sel = 0; dst_sel = 0; wb_sel = 0;
        m_reset();
        #3;
        check_val("rst.ready", 32'(ready_o[0]), 32'd1);
        check_val("rst.busy",  32'(busy_o[0]),  32'd0);
        check_val("rst.udf",   32'(udf_o[0]),   32'd0);
        check_val("rst.stall", 32'(stall_o[0]), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle("idle");

        // Reset asserted in the middle of a stall.
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, "mr_issue5");
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, "mr_stall0");
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, "mr_stall1");
        @(negedge clock);
        #2 reset = 1'b1;
        m_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            check_val("midrst.ready", 32'(ready_o[m]), 32'd1);
            check_val("midrst.busy",  32'(busy_o[m]),  32'd0);
            check_val("midrst.stall", 32'(stall_o[m]), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // RAW hazard with and without same-cycle bypass.
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, "raw_issue5");
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, "raw_stall0");
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, "raw_stall1");
        step(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, "raw_wb5");
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, "raw_after");

        // Destination counter saturation on r7.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, "sat_issue7");
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, "sat_held");
        step(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, "sat_held_wb");
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, "sat_go");
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, "sat_full_again");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, "sat_drain");

        // Issue and writeback to the same register in one cycle.
        step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, "same_issue9");
        step(1, 0, 0, 1, 9, 1, 9, 1, 9, 0, "same_both9");
        step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, "same_check");
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, "same_drain");
        idle("same_idle");

        // Underflow, and register 0 handling.
        step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, "udf_wb12");
        idle("udf_sticky");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "wb_r0");
        step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, "r0_issue");
        step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, "r0_again");

        // Flush drops all state and the concurrent issue.
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, "fl_issue3");
        step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, "fl_issue4");
        step(1, 1, 3, 0, 0, 1, 10, 1, 4, 1, "fl_flush");
        step(1, 1, 10, 1, 3, 0, 0, 0, 0, 0, "fl_after");

        // Mixed random traffic, flush kept rare.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 ($urandom_range(0, 19) == 0), "rnd");
        end

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
